// File: rtl/special_mux_arbiter_4_if.sv
// Requester/downstream bundle of the 4:1 special mux arbiter.
// The arbiter sits on the slave side; requesters and the consumer drive the master side.
interface special_mux_arbiter_4_if;
    logic [3:0] i_req;
    logic [3:0] i_last;
    logic       i_ready;
    logic [3:0] o_selection;
    logic       o_valid;
    logic [3:0] o_ack;
    logic [1:0] o_grant_id;
    logic       o_busy;
    logic       o_timeout;

    modport slave (
        input  i_req, i_last, i_ready,
        output o_selection, o_valid, o_ack, o_grant_id, o_busy, o_timeout
    );

    modport master (
        output i_req, i_last, i_ready,
        input  o_selection, o_valid, o_ack, o_grant_id, o_busy, o_timeout
    );
endinterface

// File: rtl/special_mux_arbiter_4.sv
// Round-robin burst arbiter driving the one-hot select of the shared 4:1 special mux.
// Define SPECIAL_MUX_ARB_TIMEOUT_EN to enable the MAX_HOLD forced release and o_timeout pulse.
module special_mux_arbiter_4 #(
    parameter int MAX_HOLD = 16,
    parameter int PTR_INIT = 0
) (
    input logic              i_clk,
    input logic              i_rst,
    special_mux_arbiter_4_if.slave bus
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_BUSY   = 1'b1;
    localparam logic [1:0] PTR_RESET = 2'(PTR_INIT);

    logic [0:0] state_reg;
    logic [1:0] ptr_reg;
    logic [1:0] grant_reg;
    logic [3:0] sel_reg;

    logic       win_found;
    logic [1:0] win_id;
    logic [1:0] scan_idx;
    logic [3:0] win_onehot;
    logic       req_g;
    logic       last_g;
    logic       valid;
    logic       xfer;
    logic       rel_last;
    logic       rel_hold;
    logic       rel_abandon;
    logic       rel_any;

    // Scan downward so the candidate closest to the pointer is the last one written and wins.
    always_comb begin
        win_found = 1'b0;
        win_id    = ptr_reg;
        scan_idx  = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr_reg + 2'(k);
            if (bus.i_req[scan_idx]) begin
                win_found = 1'b1;
                win_id    = scan_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign win_onehot[gi] = (win_id == 2'(gi));
            assign bus.o_ack[gi]  = xfer && (grant_reg == 2'(gi));
        end
    endgenerate

    assign req_g       = bus.i_req[grant_reg];
    assign last_g      = bus.i_last[grant_reg];
    assign valid       = (state_reg == ST_BUSY) && req_g;
    assign xfer        = valid && bus.i_ready;
    assign rel_last    = xfer && last_g;
    assign rel_abandon = (state_reg == ST_BUSY) && !req_g;
    assign rel_any     = rel_last || rel_hold || rel_abandon;

`ifdef SPECIAL_MUX_ARB_TIMEOUT_EN
    logic [7:0] beat_cnt_reg;
    logic       timeout_reg;

    // A last beat that also hits the limit is a normal release, hence the !last_g term.
    assign rel_hold = xfer && !last_g && ((beat_cnt_reg + 8'd1) == 8'(MAX_HOLD));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            beat_cnt_reg <= 8'd0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= rel_hold;
            if (state_reg == ST_IDLE) begin
                beat_cnt_reg <= 8'd0;
            end else if (xfer) begin
                beat_cnt_reg <= beat_cnt_reg + 8'd1;
            end
        end
    end

    assign bus.o_timeout = timeout_reg;
`else
    assign rel_hold      = 1'b0;
    assign bus.o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= PTR_RESET;
            grant_reg <= 2'd0;
            sel_reg   <= 4'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_found) begin
                        state_reg <= ST_BUSY;
                        sel_reg   <= win_onehot;
                        grant_reg <= win_id;
                    end
                end
                default: begin
                    // Every release passes through IDLE, giving the mandatory bubble.
                    if (rel_any) begin
                        state_reg <= ST_IDLE;
                        sel_reg   <= 4'd0;
                        ptr_reg   <= grant_reg + 2'd1;
                    end
                end
            endcase
        end
    end

    assign bus.o_selection = sel_reg;
    assign bus.o_valid     = valid;
    assign bus.o_grant_id  = grant_reg;
    assign bus.o_busy      = (state_reg == ST_BUSY);
endmodule

// File: tb/tb_special_mux_arbiter_4.sv
// Scoreboard bench for special_mux_arbiter_4: expected acks queued at stimulus time, popped on o_ack.
// Timeout expectations follow SPECIAL_MUX_ARB_TIMEOUT_EN as compiled.
module tb_special_mux_arbiter_4;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [1:0] exp_q[$];

    special_mux_arbiter_4_if bus_if ();

    special_mux_arbiter_4 #(
        .MAX_HOLD(4),
        .PTR_INIT(0)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_acks(input int id, input int n);
        repeat (n) exp_q.push_back(2'(id));
    endtask

    // Monitor: one line per acknowledged beat, compared against the scoreboard.
    always @(negedge clk) begin : mon
        logic [1:0] e;
        check("sel_onehot0", 32'($onehot0(bus_if.o_selection)), 32'd1);
        if (bus_if.o_ack != 4'd0) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 32'(bus_if.o_ack), 32'd0);
            end else begin
                e = exp_q.pop_front();
                $display("ack beat: o_ack=%b grant=%0d expected=%0d", bus_if.o_ack, bus_if.o_grant_id, e);
                check("ack", 32'(bus_if.o_ack), 32'(4'b0001 << e));
                check("ack_grant_id", 32'(bus_if.o_grant_id), 32'(e));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        bus_if.i_req   = 4'd0;
        bus_if.i_last  = 4'd0;
        bus_if.i_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) tick();
        check("rst_sel", 32'(bus_if.o_selection), 32'd0);
        check("rst_busy", 32'(bus_if.o_busy), 32'd0);
        check("rst_grant", 32'(bus_if.o_grant_id), 32'd0);
        check("rst_timeout", 32'(bus_if.o_timeout), 32'd0);
        check("rst_valid", 32'(bus_if.o_valid), 32'd0);
        check("rst_ack", 32'(bus_if.o_ack), 32'd0);
        rst_n = 1'b1;
        tick();

        // Three-beat burst on requester 0, last on beat 3.
        bus_if.i_req = 4'b0001; bus_if.i_ready = 1'b1;
        push_acks(0, 3);
        tick();
        check("s1_sel", 32'(bus_if.o_selection), 32'h1);
        check("s1_busy", 32'(bus_if.o_busy), 32'd1);
        check("s1_grant", 32'(bus_if.o_grant_id), 32'd0);
        repeat (2) tick();
        bus_if.i_last = 4'b0001;
        tick();
        check("s1_rel_sel", 32'(bus_if.o_selection), 32'd0);
        check("s1_rel_busy", 32'(bus_if.o_busy), 32'd0);
        bus_if.i_req = 4'd0; bus_if.i_last = 4'd0;

        // Pointer now 1: requesters 0 and 1 together must pick 1.
        bus_if.i_req = 4'b0011; bus_if.i_last = 4'b1111;
        push_acks(1, 1);
        tick();
        check("ptr_grant", 32'(bus_if.o_grant_id), 32'd1);
        check("ptr_sel", 32'(bus_if.o_selection), 32'h2);
        tick();
        check("ptr_rel_busy", 32'(bus_if.o_busy), 32'd0);
        bus_if.i_req = 4'd0;

        // Round robin with all four requesting, single-beat bursts.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus_if.i_req = 4'b1111; bus_if.i_last = 4'b1111; bus_if.i_ready = 1'b1;
        for (int k = 0; k < 5; k++) push_acks(order[k], 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_busy", 32'(bus_if.o_busy), 32'd1);
            check("rr_grant", 32'(bus_if.o_grant_id), 32'(order[k]));
            check("rr_sel", 32'(bus_if.o_selection), 32'(4'b0001 << order[k]));
            tick();
            check("rr_bubble_busy", 32'(bus_if.o_busy), 32'd0);
            check("rr_bubble_sel", 32'(bus_if.o_selection), 32'd0);
        end
        bus_if.i_req = 4'd0; bus_if.i_last = 4'd0;

        // Long burst on requester 2 with i_last never set.
        bus_if.i_req = 4'b0100; bus_if.i_ready = 1'b1;
`ifdef SPECIAL_MUX_ARB_TIMEOUT_EN
        push_acks(2, 4);
        tick();
        check("to_grant", 32'(bus_if.o_grant_id), 32'd2);
        repeat (3) begin
            tick();
            check("to_early_timeout", 32'(bus_if.o_timeout), 32'd0);
            check("to_early_busy", 32'(bus_if.o_busy), 32'd1);
        end
        tick();
        check("to_pulse", 32'(bus_if.o_timeout), 32'd1);
        check("to_rel_busy", 32'(bus_if.o_busy), 32'd0);
        bus_if.i_req = 4'd0;
        tick();
        check("to_pulse_end", 32'(bus_if.o_timeout), 32'd0);
        check("to_idle", 32'(bus_if.o_busy), 32'd0);
`else
        push_acks(2, 21);
        tick();
        check("nl_grant", 32'(bus_if.o_grant_id), 32'd2);
        repeat (21) begin
            tick();
            check("nl_timeout", 32'(bus_if.o_timeout), 32'd0);
            check("nl_busy", 32'(bus_if.o_busy), 32'd1);
        end
        bus_if.i_req = 4'd0;
        tick();
        check("nl_rel_busy", 32'(bus_if.o_busy), 32'd0);
        check("nl_rel_timeout", 32'(bus_if.o_timeout), 32'd0);
`endif

        // Requester 2 with ready 1,0,0,1; foreign i_last bits must be ignored.
        bus_if.i_req = 4'b0100; bus_if.i_ready = 1'b0; bus_if.i_last = 4'b1011;
        push_acks(2, 2);
        tick();
        check("rdy_grant", 32'(bus_if.o_grant_id), 32'd2);
        bus_if.i_ready = 1'b1;
        tick();
        bus_if.i_ready = 1'b0;
        tick();
        check("rdy_valid", 32'(bus_if.o_valid), 32'd1);
        check("rdy_no_ack", 32'(bus_if.o_ack), 32'd0);
        check("rdy_busy", 32'(bus_if.o_busy), 32'd1);
        tick();
        bus_if.i_ready = 1'b1;
        tick();
        check("rdy_still_busy", 32'(bus_if.o_busy), 32'd1);
        bus_if.i_req = 4'd0;
        tick();
        check("abandon_busy", 32'(bus_if.o_busy), 32'd0);
        check("abandon_timeout", 32'(bus_if.o_timeout), 32'd0);
        check("abandon_sel", 32'(bus_if.o_selection), 32'd0);
        bus_if.i_last = 4'd0;

        // Asynchronous reset mid-burst on requester 3.
        bus_if.i_req = 4'b1000; bus_if.i_ready = 1'b1;
        tick();
        check("ar_grant", 32'(bus_if.o_grant_id), 32'd3);
        check("ar_busy", 32'(bus_if.o_busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("ar_sel", 32'(bus_if.o_selection), 32'd0);
        check("ar_busy_low", 32'(bus_if.o_busy), 32'd0);
        check("ar_valid", 32'(bus_if.o_valid), 32'd0);
        check("ar_ack", 32'(bus_if.o_ack), 32'd0);
        bus_if.i_req = 4'd0;
        tick();
        rst_n = 1'b1;
        bus_if.i_req = 4'b1001; bus_if.i_last = 4'b1111;
        push_acks(0, 1);
        tick();
        check("ar_ptr_init", 32'(bus_if.o_grant_id), 32'd0);
        tick();
        check("ar_rel_busy", 32'(bus_if.o_busy), 32'd0);
        bus_if.i_req = 4'd0; bus_if.i_last = 4'd0;

        // i_last on the beat that reaches MAX_HOLD: normal release.
        bus_if.i_req = 4'b0010; bus_if.i_ready = 1'b1;
        push_acks(1, 4);
        tick();
        check("lh_grant", 32'(bus_if.o_grant_id), 32'd1);
        repeat (3) tick();
        bus_if.i_last = 4'b0010;
        tick();
        check("lh_rel_busy", 32'(bus_if.o_busy), 32'd0);
        check("lh_timeout", 32'(bus_if.o_timeout), 32'd0);
        bus_if.i_req = 4'd0; bus_if.i_last = 4'd0;
        tick();
        check("lh_timeout_after", 32'(bus_if.o_timeout), 32'd0);

        repeat (3) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
